// File: rtl/pulpino_mailbox_pkg.sv
// Shared register map, STATUS layout and address decode for the PULPino external mailbox.
package pulpino_mailbox_pkg;

    localparam logic [7:0] OFF_RXDATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_TXDATA   = 8'h08;
    localparam logic [7:0] OFF_TXFLAGS  = 8'h0C;
    localparam logic [7:0] OFF_EXTFLAGS = 8'h10;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h14;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_COUNT_LSB = 2;
    localparam int STATUS_COUNT_MSB = 7;
    localparam int STATUS_OVF_BIT   = 8;
    localparam int STATUS_COUNT_W   = STATUS_COUNT_MSB - STATUS_COUNT_LSB + 1;

    localparam int IRQ_EN_RX_BIT  = 0;
    localparam int IRQ_EN_OVF_BIT = 1;

    typedef enum logic [2:0] {
        SEL_RXDATA,
        SEL_STATUS,
        SEL_TXDATA,
        SEL_TXFLAGS,
        SEL_EXTFLAGS,
        SEL_IRQ_EN,
        SEL_NONE
    } reg_sel_e;

    // Address is zero-extended by the caller; any set bit above the offset byte is unmapped.
    function automatic reg_sel_e decode_offset(input logic [31:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr[31:8] == 24'h0) begin
            case (addr[7:0])
                OFF_RXDATA:   sel = SEL_RXDATA;
                OFF_STATUS:   sel = SEL_STATUS;
                OFF_TXDATA:   sel = SEL_TXDATA;
                OFF_TXFLAGS:  sel = SEL_TXFLAGS;
                OFF_EXTFLAGS: sel = SEL_EXTFLAGS;
                OFF_IRQ_EN:   sel = SEL_IRQ_EN;
                default:      sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] status_word(
        input logic                      empty,
        input logic                      full,
        input logic [STATUS_COUNT_W-1:0] count,
        input logic                      overflow
    );
        logic [31:0] w;
        w = 32'h0;
        w[STATUS_EMPTY_BIT] = empty;
        w[STATUS_FULL_BIT]  = full;
        w[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count;
        w[STATUS_OVF_BIT]   = overflow;
        return w;
    endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Small RX FIFO with combinational head read; simultaneous push/pop is legal even when full.
module mailbox_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == CNT_W'(0));
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = mem[rd_ptr];

    // A push into a full FIFO only lands if the head is leaving in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pulpino_ext_mailbox.sv
// Host <-> PULPino mailbox: synchronized host strobe pushes words into an RX FIFO,
// APB slave exposes RX/TX data, flags, status and a level interrupt.
module pulpino_ext_mailbox
    import pulpino_mailbox_pkg::*;
#(
    parameter int pFIFO_DEPTH     = 4,
    parameter int pAPB_ADDR_WIDTH = 12
) (
    input  logic                       crypto_clk,
    input  logic                       rst_n,
    input  logic [31:0]                usb_to_pulpino,
    input  logic                       usb_to_pulpino_read,
    input  logic [31:0]                ext_to_pulpino_flags,
    output logic [31:0]                pulpino_to_usb,
    output logic [31:0]                pulpino_to_ext_flags,
    input  logic [pAPB_ADDR_WIDTH-1:0] paddr,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [31:0]                pwdata,
    output logic [31:0]                prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic                       irq_o
);

    localparam int CNT_W = $clog2(pFIFO_DEPTH + 1);

    logic             usb_read_p0;
    logic             usb_read_p1;
    logic             usb_read_p2;
    logic             vld_p0;
    logic             vld_p1;
    logic             push_armed;
    logic             push_evt;
    logic [31:0]      ext_flags_p0;
    logic [31:0]      ext_flags_p1;

    logic [31:0]      tx_data;
    logic [31:0]      tx_flags;
    logic [1:0]       irq_en;
    logic             overflow;

    logic             fifo_pop;
    logic [31:0]      fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic             access;
    logic             wr_access;
    logic [31:0]      addr_ext;
    reg_sel_e         sel;

    assign pready = 1'b1;

    // Stage p0/p1: two-flop synchronizers; vld_pN marks when p1 holds a genuinely sampled value.
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            usb_read_p0  <= 1'b0;
            usb_read_p1  <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            ext_flags_p0 <= '0;
            ext_flags_p1 <= '0;
        end else begin
            usb_read_p0  <= usb_to_pulpino_read;
            usb_read_p1  <= usb_read_p0;
            vld_p0       <= 1'b1;
            vld_p1       <= vld_p0;
            ext_flags_p0 <= ext_to_pulpino_flags;
            ext_flags_p1 <= ext_flags_p0;
        end
    end

    // Stage p2: edge detect, armed only once a real low has been observed after reset.
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            usb_read_p2 <= 1'b0;
            push_armed  <= 1'b0;
        end else begin
            usb_read_p2 <= usb_read_p1;
            if (vld_p1 && !usb_read_p1) begin
                push_armed <= 1'b1;
            end
        end
    end

    assign push_evt = push_armed & usb_read_p1 & ~usb_read_p2;

    assign access    = psel & penable;
    assign wr_access = access & pwrite;
    assign addr_ext  = 32'(paddr);
    assign sel       = decode_offset(addr_ext);
    assign fifo_pop  = access & ~pwrite & (sel == SEL_RXDATA) & ~fifo_empty;

    mailbox_fifo #(
        .DEPTH (pFIFO_DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (crypto_clk),
        .rst_n (rst_n),
        .push  (push_evt),
        .pop   (fifo_pop),
        .wdata (usb_to_pulpino),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        prdata  = 32'h0;
        pslverr = 1'b0;
        if (access) begin
            case (sel)
                SEL_RXDATA: begin
                    if (pwrite || fifo_empty) begin
                        pslverr = 1'b1;
                    end else begin
                        prdata = fifo_rdata;
                    end
                end
                SEL_STATUS: begin
                    if (!pwrite) begin
                        prdata = status_word(fifo_empty, fifo_full,
                                             STATUS_COUNT_W'(fifo_count), overflow);
                    end
                end
                SEL_TXDATA:  prdata = pwrite ? 32'h0 : tx_data;
                SEL_TXFLAGS: prdata = pwrite ? 32'h0 : tx_flags;
                SEL_EXTFLAGS: begin
                    if (pwrite) begin
                        pslverr = 1'b1;
                    end else begin
                        prdata = ext_flags_p1;
                    end
                end
                SEL_IRQ_EN:  prdata = pwrite ? 32'h0 : {30'h0, irq_en};
                default:     pslverr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_flags <= '0;
            irq_en   <= '0;
        end else if (wr_access) begin
            case (sel)
                SEL_TXDATA:  tx_data  <= pwdata;
                SEL_TXFLAGS: tx_flags <= pwdata;
                SEL_IRQ_EN:  irq_en   <= pwdata[1:0];
                default:     ;
            endcase
        end
    end

    // A new overflow in the same cycle as the W1C clear wins, so no event is lost.
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_evt && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (wr_access && sel == SEL_STATUS && pwdata[STATUS_OVF_BIT]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (irq_en[IRQ_EN_RX_BIT] & ~fifo_empty) |
                     (irq_en[IRQ_EN_OVF_BIT] & overflow);
        end
    end

    assign pulpino_to_usb       = tx_data;
    assign pulpino_to_ext_flags = tx_flags;

endmodule
